control_sequencer: RTL

- Hardware control unit that drives the datapath's control-signal interface.
- Replaces hand-sequenced bench stimulus with an FSM stepping fetch (T0–T2) then opcode-specific execute steps (T3–T7).
- Sits beside the datapath: consumes IR and the CON flag, and produces every register in/out strobe, memory strobes and register-select lines.
- One control step per clock.

---
 rtl/cpu_ctrl_pkg.sv | 52 +++++
 rtl/ctrl_opcode_class.sv | 31 +++
 rtl/control_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcode constants, sequencer states and instruction classes
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALTED
  } state_t;

  typedef enum logic [3:0] {
    CLS_REG_ALU, CLS_IMM_ALU, CLS_UNARY, CLS_MULDIV, CLS_LDI, CLS_LD, CLS_ST,
    CLS_BR, CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
  } instr_class_t;

  // Final execute step of each class; Stop and halt are resolved on this step.
  function automatic state_t last_step(instr_class_t c);
    case (c)
      CLS_REG_ALU, CLS_IMM_ALU, CLS_LDI: last_step = ST_T5;
      CLS_UNARY:                         last_step = ST_T4;
      CLS_MULDIV, CLS_BR:                last_step = ST_T6;
      CLS_LD, CLS_ST:                    last_step = ST_T7;
      default:                           last_step = ST_T3;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_opcode_class.sv
// rtl/ctrl_opcode_class.sv - combinational opcode to instruction-class decoder
module ctrl_opcode_class
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [3:0] op_class
);

  always_comb begin
    op_class = CLS_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
        op_class = CLS_REG_ALU;
      OP_ADDI, OP_ANDI, OP_ORI: op_class = CLS_IMM_ALU;
      OP_NEG, OP_NOT:           op_class = CLS_UNARY;
      OP_MUL, OP_DIV:           op_class = CLS_MULDIV;
      OP_LDI:                   op_class = CLS_LDI;
      OP_LD:                    op_class = CLS_LD;
      OP_ST:                    op_class = CLS_ST;
      OP_BR:                    op_class = CLS_BR;
      OP_JR:                    op_class = CLS_JR;
      OP_IN:                    op_class = CLS_IN;
      OP_OUT:                   op_class = CLS_OUT;
      OP_MFHI:                  op_class = CLS_MFHI;
      OP_MFLO:                  op_class = CLS_MFLO;
      OP_HALT:                  op_class = CLS_HALT;
      default:                  op_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute control FSM driving datapath strobes
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_WIDTH = 32,
  parameter int OPC_LSB  = 27
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Stop,
  input  logic [IR_WIDTH-1:0] IR,
  input  logic                CON,
  output logic                Run,
  output logic                HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
  output logic                HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
  output logic                Gra, Grb, Grc, Rin, Rout, BAout,
  output logic                Read, Write, IncPC
);

  localparam logic [IR_WIDTH-1:0] OPC_MASK = {{(IR_WIDTH-5){1'b0}}, 5'h1f} << OPC_LSB;

  state_t       state, next_state;
  logic [3:0]   op_class;
  instr_class_t cls;
  logic         ir_unused;

  assign ir_unused = ^(IR & ~OPC_MASK);

  ctrl_opcode_class u_class (
    .opcode   (IR[OPC_LSB+4:OPC_LSB]),
    .op_class (op_class)
  );

  assign cls = instr_class_t'(op_class);

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_RST;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    Run = 1'b0;
    case (state)
      ST_RST:    next_state = ST_T0;
      ST_HALTED: next_state = ST_HALTED;
      default: begin
        Run = 1'b1;
        if (state == last_step(cls))
          next_state = (cls == CLS_HALT || Stop) ? ST_HALTED : ST_T0;
        else
          next_state = state_t'(state + 4'd1);
      end
    endcase
  end

  always_comb begin
    {HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin} = '0;
    {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout}    = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC}             = '0;
    case (state)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (cls)
          CLS_REG_ALU, CLS_IMM_ALU: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_UNARY:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          CLS_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_LDI, CLS_LD, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CLS_BR:     begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          CLS_JR:     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          CLS_IN:     begin INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_OUT:    begin Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1; end
          CLS_MFHI:   begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_MFLO:   begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_REG_ALU: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          CLS_IMM_ALU, CLS_LDI, CLS_LD, CLS_ST: begin Cout = 1'b1; Zin = 1'b1; end
          CLS_UNARY:   begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_MULDIV:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          CLS_BR:      begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_REG_ALU, CLS_IMM_ALU, CLS_LDI: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_MULDIV:     begin ZLOout = 1'b1; LOin = 1'b1; end
          CLS_LD, CLS_ST: begin ZLOout = 1'b1; MARin = 1'b1; end
          CLS_BR:         begin Cout = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CLS_MULDIV: begin ZHIout = 1'b1; HIin = 1'b1; end
          CLS_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          CLS_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          // A not-taken branch still spends this cycle, just with no strobes.
          CLS_BR:     begin ZLOout = CON; PCin = CON; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CLS_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
